nios2_debug_vjtag_master: RTL

Single-clock sequencer that drives the virtual-JTAG side of the Nios II debug slave (ir_in, vs_uir/vs_cdr/vs_sdr/vs_udr, tdi, rti) and collects tdo. A test or bridge master issues a 2-bit IR plus a 38-bit scan word over a valid/ready command port. The block runs one full IR-update / capture / shift / update / run-test-idle sequence and returns the 38 captured tdo bits on a valid/ready response port. It lets simulation and on-chip debug bridges reach the debug slave without a physical JTAG chain.

---
 rtl/nios2_debug_vjtag_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nios2_debug_vjtag_master.sv
// rtl/nios2_debug_vjtag_master.sv - virtual-JTAG sequencer driving the Nios II debug slave
`timescale 1ns/1ps
module nios2_debug_vjtag_master #(
    parameter int SR_WIDTH = 38,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [1:0]          ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tdi,
    input  logic                tdo
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(SR_WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [SR_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]          ir_q, ir_d;
    logic                div_last;

    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ir_d    = cmd_ir;
                    shift_d = cmd_data;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = S_UIR;
                end
            end
            S_UIR, S_CDR, S_UDR, S_RTI: begin
                if (div_last) begin
                    div_d = '0;
                    case (state_q)
                        S_UIR:   state_d = S_CDR;
                        S_CDR:   state_d = S_SDR;
                        S_UDR:   state_d = S_RTI;
                        default: state_d = S_RSP;
                    endcase
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SDR: begin
                if (div_last) begin
                    div_d = '0;
                    // Shift right: tdo enters at the MSB so bit i ends up holding period i's sample.
                    for (int i = 0; i < SR_WIDTH - 1; i++) begin
                        shift_d[i] = shift_q[i+1];
                    end
                    shift_d[SR_WIDTH-1] = tdo;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_UDR;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_RSP);
    assign rsp_data       = shift_q;
    assign ir_in          = ir_q;
    assign vs_uir         = (state_q == S_UIR);
    assign vs_cdr         = (state_q == S_CDR);
    assign vs_sdr         = (state_q == S_SDR);
    assign vs_udr         = (state_q == S_UDR);
    assign jtag_state_rti = (state_q == S_RTI);
    assign tdi            = (state_q == S_SDR) ? shift_q[0] : 1'b0;

endmodule
